raster_traverser: RTL and testbench

Triangle traversal unit that sits upstream of `pixel_processor` and drives its pixel input stream. It accepts one triangle setup record: a screen-space bounding box, three edge-function values at the box origin with per-pixel X/Y steps, a depth start value with `dzdx`/`dzdy`, and metadata. It walks the box in raster order and evaluates edges and depth incrementally, so no multipliers are used. Per pixel it emits the coordinates, the three edge values, the interpolated Z and the metadata over a valid/ready handshake.

---
 rtl/raster_traverser_if.sv | 66 ++++++
 rtl/raster_traverser.sv | 217 +++++++++++++++++++++
 tb/tb_raster_traverser.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_traverser_if.sv
`default_nettype none
// ============================================================================
// Module   : raster_traverser_if
// Purpose  : Setup-record and pixel-stream handshake bundle of the traverser.
// Revision : 1.0
// ============================================================================
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif

interface raster_traverser_if #(
  parameter int FX = `FX_TOTAL_BITS,
  parameter int CW = 11,
  parameter int MW = 8
);
  logic                   tri_vld;
  logic                   tri_rdy;
  logic [CW-1:0]          tri_min_x;
  logic [CW-1:0]          tri_min_y;
  logic [CW-1:0]          tri_max_x;
  logic [CW-1:0]          tri_max_y;
  logic signed [2*FX-1:0] tri_e0;
  logic signed [2*FX-1:0] tri_e1;
  logic signed [2*FX-1:0] tri_e2;
  logic signed [2*FX-1:0] tri_e0_dx;
  logic signed [2*FX-1:0] tri_e1_dx;
  logic signed [2*FX-1:0] tri_e2_dx;
  logic signed [2*FX-1:0] tri_e0_dy;
  logic signed [2*FX-1:0] tri_e1_dy;
  logic signed [2*FX-1:0] tri_e2_dy;
  logic [2*FX-1:0]        tri_z;
  logic signed [FX-1:0]   tri_dzdx;
  logic signed [FX-1:0]   tri_dzdy;
  logic [MW-1:0]          tri_metadata;
  logic                   tri_done;
  logic                   px_vld;
  logic                   px_rdy;
  logic [CW-1:0]          px_x;
  logic [CW-1:0]          px_y;
  logic signed [2*FX-1:0] px_edge_0;
  logic signed [2*FX-1:0] px_edge_1;
  logic signed [2*FX-1:0] px_edge_2;
  logic [2*FX-1:0]        px_z;
  logic [MW-1:0]          px_metadata;

  // master: the traverser itself
  modport master (
    input  tri_vld, tri_min_x, tri_min_y, tri_max_x, tri_max_y,
           tri_e0, tri_e1, tri_e2, tri_e0_dx, tri_e1_dx, tri_e2_dx,
           tri_e0_dy, tri_e1_dy, tri_e2_dy, tri_z, tri_dzdx, tri_dzdy,
           tri_metadata, px_rdy,
    output tri_rdy, tri_done, px_vld, px_x, px_y, px_edge_0, px_edge_1,
           px_edge_2, px_z, px_metadata
  );

  modport slave (
    output tri_vld, tri_min_x, tri_min_y, tri_max_x, tri_max_y,
           tri_e0, tri_e1, tri_e2, tri_e0_dx, tri_e1_dx, tri_e2_dx,
           tri_e0_dy, tri_e1_dy, tri_e2_dy, tri_z, tri_dzdx, tri_dzdy,
           tri_metadata, px_rdy,
    input  tri_rdy, tri_done, px_vld, px_x, px_y, px_edge_0, px_edge_1,
           px_edge_2, px_z, px_metadata
  );
endinterface

`default_nettype wire

// File: rtl/raster_traverser.sv
`default_nettype none
// ============================================================================
// Module   : raster_traverser
// Purpose  : Walks a triangle bounding box in raster order, stepping edge and
//            depth values incrementally and streaming pixels downstream.
// Revision : 1.0
// ============================================================================
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif

module raster_traverser #(
  parameter int FX   = `FX_TOTAL_BITS,
  parameter int CW   = 11,
  parameter int MW   = 8,
  parameter bit CULL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  raster_traverser_if.master  bus
);
  localparam int AW = 2 * FX;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WALK = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic tri_rdy_q, tri_rdy_d, tri_done_q, tri_done_d;
  logic deg_q, deg_d, px_vld_q, px_vld_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;
  logic [2:0][AW-1:0] e_cur_q, e_cur_d, e_row_q, e_row_d;
  logic [2:0][AW-1:0] e_dx_q, e_dx_d, e_dy_q, e_dy_d;
  logic [AW-1:0] z_cur_q, z_cur_d, z_row_q, z_row_d;
  logic [AW-1:0] dzdx_q, dzdx_d, dzdy_q, dzdy_d;
  logic [MW-1:0] meta_q, meta_d;
  logic [CW-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [2:0][AW-1:0] px_e_q, px_e_d;
  logic [AW-1:0] px_z_q, px_z_d;
  logic [MW-1:0] px_meta_q, px_meta_d;

  logic slot_free, accept, degenerate, row_end, last_px, emit;

  assign slot_free  = !px_vld_q || bus.px_rdy;
  assign accept     = (state_q == S_IDLE) && tri_rdy_q && !deg_q && bus.tri_vld;
  assign degenerate = (bus.tri_max_x < bus.tri_min_x) || (bus.tri_max_y < bus.tri_min_y);
  assign row_end    = (x_q == max_x_q);
  assign last_px    = row_end && (y_q == max_y_q);

  generate
    if (CULL) begin : g_cull
      assign emit = !e_cur_q[0][AW-1] && !e_cur_q[1][AW-1] && !e_cur_q[2][AW-1];
    end else begin : g_no_cull
      assign emit = 1'b1;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    tri_rdy_d  = tri_rdy_q;
    tri_done_d = 1'b0;
    deg_d      = deg_q;
    px_vld_d   = px_vld_q;
    x_d        = x_q;
    y_d        = y_q;
    min_x_d    = min_x_q;
    max_x_d    = max_x_q;
    max_y_d    = max_y_q;
    e_cur_d    = e_cur_q;
    e_row_d    = e_row_q;
    e_dx_d     = e_dx_q;
    e_dy_d     = e_dy_q;
    z_cur_d    = z_cur_q;
    z_row_d    = z_row_q;
    dzdx_d     = dzdx_q;
    dzdy_d     = dzdy_q;
    meta_d     = meta_q;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_e_d     = px_e_q;
    px_z_d     = px_z_q;
    px_meta_d  = px_meta_q;

    case (state_q)
      S_IDLE: begin
        tri_rdy_d = 1'b1;
        // the last pixel of the previous triangle may still be draining
        if (px_vld_q && bus.px_rdy) px_vld_d = 1'b0;
        if (deg_q) begin
          deg_d      = 1'b0;
          tri_done_d = 1'b1;
        end else if (accept) begin
          tri_rdy_d = 1'b0;
          x_d       = bus.tri_min_x;
          y_d       = bus.tri_min_y;
          min_x_d   = bus.tri_min_x;
          max_x_d   = bus.tri_max_x;
          max_y_d   = bus.tri_max_y;
          e_cur_d   = {bus.tri_e2, bus.tri_e1, bus.tri_e0};
          e_row_d   = {bus.tri_e2, bus.tri_e1, bus.tri_e0};
          e_dx_d    = {bus.tri_e2_dx, bus.tri_e1_dx, bus.tri_e0_dx};
          e_dy_d    = {bus.tri_e2_dy, bus.tri_e1_dy, bus.tri_e0_dy};
          z_cur_d   = bus.tri_z;
          z_row_d   = bus.tri_z;
          dzdx_d    = {{FX{bus.tri_dzdx[FX-1]}}, bus.tri_dzdx};
          dzdy_d    = {{FX{bus.tri_dzdy[FX-1]}}, bus.tri_dzdy};
          meta_d    = bus.tri_metadata;
          if (degenerate) deg_d = 1'b1;
          else            state_d = S_WALK;
        end
      end
      S_WALK: begin
        if (slot_free) begin
          if (emit) begin
            px_vld_d  = 1'b1;
            px_x_d    = x_q;
            px_y_d    = y_q;
            px_e_d    = e_cur_q;
            px_z_d    = z_cur_q;
            px_meta_d = meta_q;
          end else begin
            px_vld_d  = 1'b0;
          end
          if (last_px) begin
            state_d    = S_IDLE;
            tri_done_d = 1'b1;
            tri_rdy_d  = 1'b1;
          end else if (row_end) begin
            x_d = min_x_q;
            y_d = y_q + CW'(1);
            for (int i = 0; i < 3; i++) begin
              e_row_d[i] = e_row_q[i] + e_dy_q[i];
              e_cur_d[i] = e_row_q[i] + e_dy_q[i];
            end
            z_row_d = z_row_q + dzdy_q;
            z_cur_d = z_row_q + dzdy_q;
          end else begin
            x_d = x_q + CW'(1);
            for (int i = 0; i < 3; i++) e_cur_d[i] = e_cur_q[i] + e_dx_q[i];
            z_cur_d = z_cur_q + dzdx_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tri_rdy_q  <= 1'b0;
      tri_done_q <= 1'b0;
      deg_q      <= 1'b0;
      px_vld_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      max_y_q    <= '0;
      e_cur_q    <= '0;
      e_row_q    <= '0;
      e_dx_q     <= '0;
      e_dy_q     <= '0;
      z_cur_q    <= '0;
      z_row_q    <= '0;
      dzdx_q     <= '0;
      dzdy_q     <= '0;
      meta_q     <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_e_q     <= '0;
      px_z_q     <= '0;
      px_meta_q  <= '0;
    end else begin
      state_q    <= state_d;
      tri_rdy_q  <= tri_rdy_d;
      tri_done_q <= tri_done_d;
      deg_q      <= deg_d;
      px_vld_q   <= px_vld_d;
      x_q        <= x_d;
      y_q        <= y_d;
      min_x_q    <= min_x_d;
      max_x_q    <= max_x_d;
      max_y_q    <= max_y_d;
      e_cur_q    <= e_cur_d;
      e_row_q    <= e_row_d;
      e_dx_q     <= e_dx_d;
      e_dy_q     <= e_dy_d;
      z_cur_q    <= z_cur_d;
      z_row_q    <= z_row_d;
      dzdx_q     <= dzdx_d;
      dzdy_q     <= dzdy_d;
      meta_q     <= meta_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_e_q     <= px_e_d;
      px_z_q     <= px_z_d;
      px_meta_q  <= px_meta_d;
    end
  end

  assign bus.tri_rdy     = tri_rdy_q;
  assign bus.tri_done    = tri_done_q;
  assign bus.px_vld      = px_vld_q;
  assign bus.px_x        = px_x_q;
  assign bus.px_y        = px_y_q;
  assign bus.px_edge_0   = px_e_q[0];
  assign bus.px_edge_1   = px_e_q[1];
  assign bus.px_edge_2   = px_e_q[2];
  assign bus.px_z        = px_z_q;
  assign bus.px_metadata = px_meta_q;

endmodule

`default_nettype wire

// File: tb/tb_raster_traverser.sv
`default_nettype none
// ============================================================================
// Module   : tb_raster_traverser
// Purpose  : Directed table-driven bench for raster_traverser (CULL=1 and 0).
// Revision : 1.0
// ============================================================================
module tb_raster_traverser;
  localparam int FX = 16;
  localparam int CW = 11;
  localparam int MW = 8;

  typedef struct { int x, y, e0, e1, e2, z, meta; } pix_t;
  typedef struct { int tc; pix_t p; } vec_t;
  typedef struct {
    int min_x, min_y, max_x, max_y;
    int e0, e1, e2, e0dx, e1dx, e2dx, e0dy, e1dy, e2dy;
    int z, dzdx, dzdy, meta;
  } tri_t;

  logic clk, rst_n, tri_vld, px_rdy, sel, stall_mode;
  tri_t cur;
  int checks = 0;
  int failures = 0;

  raster_traverser_if #(.FX(FX), .CW(CW), .MW(MW)) if0 ();
  raster_traverser_if #(.FX(FX), .CW(CW), .MW(MW)) if1 ();

`define TB_DRIVE(I, S) \
  assign I.tri_vld = tri_vld & (sel == S); \
  assign I.px_rdy = px_rdy; \
  assign I.tri_min_x = CW'(cur.min_x); assign I.tri_min_y = CW'(cur.min_y); \
  assign I.tri_max_x = CW'(cur.max_x); assign I.tri_max_y = CW'(cur.max_y); \
  assign I.tri_e0 = cur.e0; assign I.tri_e1 = cur.e1; assign I.tri_e2 = cur.e2; \
  assign I.tri_e0_dx = cur.e0dx; assign I.tri_e1_dx = cur.e1dx; assign I.tri_e2_dx = cur.e2dx; \
  assign I.tri_e0_dy = cur.e0dy; assign I.tri_e1_dy = cur.e1dy; assign I.tri_e2_dy = cur.e2dy; \
  assign I.tri_z = cur.z; assign I.tri_dzdx = FX'(cur.dzdx); assign I.tri_dzdy = FX'(cur.dzdy); \
  assign I.tri_metadata = MW'(cur.meta);

  `TB_DRIVE(if0, 1'b0)
  `TB_DRIVE(if1, 1'b1)
`undef TB_DRIVE

  raster_traverser #(.FX(FX), .CW(CW), .MW(MW), .CULL(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.master));
  raster_traverser #(.FX(FX), .CW(CW), .MW(MW), .CULL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master));

  logic m_vld, m_rdy, m_done;
  logic [CW-1:0] m_x, m_y;
  logic signed [2*FX-1:0] m_e0, m_e1, m_e2;
  logic [2*FX-1:0] m_z;
  logic [MW-1:0] m_meta;
  assign m_vld  = sel ? if1.px_vld      : if0.px_vld;
  assign m_rdy  = sel ? if1.tri_rdy     : if0.tri_rdy;
  assign m_done = sel ? if1.tri_done    : if0.tri_done;
  assign m_x    = sel ? if1.px_x        : if0.px_x;
  assign m_y    = sel ? if1.px_y        : if0.px_y;
  assign m_e0   = sel ? if1.px_edge_0   : if0.px_edge_0;
  assign m_e1   = sel ? if1.px_edge_1   : if0.px_edge_1;
  assign m_e2   = sel ? if1.px_edge_2   : if0.px_edge_2;
  assign m_z    = sel ? if1.px_z        : if0.px_z;
  assign m_meta = sel ? if1.px_metadata : if0.px_metadata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream ready: constant 1 or a repeating stall pattern
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    int pidx;
    pidx = 0;
    px_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_mode) begin
        px_rdy = pat[pidx];
        pidx = (pidx + 1) % 6;
      end else begin
        px_rdy = 1'b1;
      end
    end
  end

  function automatic bit pix_eq(input pix_t a, input pix_t b);
    return a.x == b.x && a.y == b.y && a.e0 == b.e0 && a.e1 == b.e1 &&
           a.e2 == b.e2 && a.z == b.z && a.meta == b.meta;
  endfunction

  // monitor: handshakes, done pulses and stall stability
  int cyc = 0;
  int done_cnt = 0;
  int vld_cnt = 0;
  pix_t got_q[$];
  int got_cyc[$];
  bit prev_stall = 1'b0;
  pix_t held;
  always @(negedge clk) begin
    pix_t p;
    cyc++;
    p.x = int'(m_x); p.y = int'(m_y); p.e0 = m_e0; p.e1 = m_e1; p.e2 = m_e2;
    p.z = m_z; p.meta = int'(m_meta);
    if (rst_n) begin
      if (m_done) done_cnt++;
      if (m_vld) vld_cnt++;
      if (prev_stall) begin
        checks++;
        if (!m_vld || !pix_eq(p, held)) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got vld=%0b x=%0d y=%0d e0=%0d z=%0d req x=%0d y=%0d e0=%0d z=%0d",
                   cyc, m_vld, p.x, p.y, p.e0, p.z, held.x, held.y, held.e0, held.z);
        end
      end
      if (m_vld && px_rdy) begin
        got_q.push_back(p);
        got_cyc.push_back(cyc);
      end
      prev_stall = m_vld && !px_rdy;
      held = p;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d req=%0d", nm, got, exp);
    end
  endtask

  vec_t vecs[$];
  tri_t tris[7];

  function automatic vec_t mk(input int tc, x, y, e0, e1, e2, z, meta);
    vec_t v;
    v.tc = tc; v.p.x = x; v.p.y = y; v.p.e0 = e0; v.p.e1 = e1; v.p.e2 = e2;
    v.p.z = z; v.p.meta = meta;
    return v;
  endfunction

  task automatic check_case(input int tc, input string nm);
    pix_t ex[$];
    foreach (vecs[i]) if (vecs[i].tc == tc) ex.push_back(vecs[i].p);
    chk({nm, "_count"}, got_q.size(), ex.size());
    for (int k = 0; k < ex.size() && k < got_q.size(); k++) begin
      checks++;
      if (!pix_eq(got_q[k], ex[k])) begin
        failures++;
        $display("FAIL %s_pix%0d got (%0d,%0d) e=%0d/%0d/%0d z=%0d m=%0d req (%0d,%0d) e=%0d/%0d/%0d z=%0d m=%0d",
                 nm, k, got_q[k].x, got_q[k].y, got_q[k].e0, got_q[k].e1, got_q[k].e2,
                 got_q[k].z, got_q[k].meta, ex[k].x, ex[k].y, ex[k].e0, ex[k].e1,
                 ex[k].e2, ex[k].z, ex[k].meta);
      end
    end
  endtask

  task automatic send_tri(input tri_t t, output int acc_n);
    int n;
    n = 0;
    cur = t;
    while (!m_rdy && n < 50) begin @(posedge clk); #1; n++; end
    if (!m_rdy) begin checks++; failures++; $display("FAIL tri_rdy_timeout got=0 req=1"); end
    tri_vld = 1'b1;
    acc_n = cyc + 1;
    @(posedge clk); #1;
    tri_vld = 1'b0;
  endtask

  task automatic run_tri(input tri_t t, input int tc, input string nm, output int acc_n);
    int d0, n;
    got_q.delete();
    got_cyc.delete();
    d0 = done_cnt;
    send_tri(t, acc_n);
    n = 0;
    while ((done_cnt < d0 + 1 || m_vld) && n < 300) begin @(posedge clk); #1; n++; end
    if (n >= 300) begin checks++; failures++; $display("FAIL %s_timeout got=busy req=done", nm); end
    repeat (2) begin @(posedge clk); #1; end
    chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    check_case(tc, nm);
  endtask

  initial begin
    int acc, d0, v0, n;
    rst_n = 1'b0; tri_vld = 1'b0; sel = 1'b0; stall_mode = 1'b0;
    cur = '{default: 0};

    // triangle setups
    tris[1] = '{min_x:3, min_y:4, max_x:3, max_y:4, e0:5, e1:5, e2:5, e0dx:0, e1dx:0, e2dx:0,
                e0dy:0, e1dy:0, e2dy:0, z:100, dzdx:0, dzdy:0, meta:8'hA1};
    tris[2] = '{min_x:0, min_y:0, max_x:3, max_y:1, e0:10, e1:1, e2:1, e0dx:1, e1dx:0, e2dx:0,
                e0dy:16, e1dy:0, e2dy:0, z:50, dzdx:-2, dzdy:3, meta:8'h5C};
    tris[4] = '{min_x:0, min_y:0, max_x:3, max_y:0, e0:-2, e1:0, e2:0, e0dx:1, e1dx:0, e2dx:0,
                e0dy:0, e1dy:0, e2dy:0, z:7, dzdx:0, dzdy:0, meta:8'h33};
    tris[6] = '{min_x:5, min_y:0, max_x:2, max_y:3, e0:1, e1:1, e2:1, e0dx:0, e1dx:0, e2dx:0,
                e0dy:0, e1dy:0, e2dy:0, z:9, dzdx:0, dzdy:0, meta:8'h01};

    // expected pixel streams per test id
    vecs.push_back(mk(1, 3, 4,  5, 5, 5, 100, 8'hA1));
    vecs.push_back(mk(2, 0, 0, 10, 1, 1, 50, 8'h5C));
    vecs.push_back(mk(2, 1, 0, 11, 1, 1, 48, 8'h5C));
    vecs.push_back(mk(2, 2, 0, 12, 1, 1, 46, 8'h5C));
    vecs.push_back(mk(2, 3, 0, 13, 1, 1, 44, 8'h5C));
    vecs.push_back(mk(2, 0, 1, 26, 1, 1, 53, 8'h5C));
    vecs.push_back(mk(2, 1, 1, 27, 1, 1, 51, 8'h5C));
    vecs.push_back(mk(2, 2, 1, 28, 1, 1, 49, 8'h5C));
    vecs.push_back(mk(2, 3, 1, 29, 1, 1, 47, 8'h5C));
    vecs.push_back(mk(4, 2, 0,  0, 0, 0, 7, 8'h33));
    vecs.push_back(mk(4, 3, 0,  1, 0, 0, 7, 8'h33));
    vecs.push_back(mk(5, 0, 0, -2, 0, 0, 7, 8'h33));
    vecs.push_back(mk(5, 1, 0, -1, 0, 0, 7, 8'h33));
    vecs.push_back(mk(5, 2, 0,  0, 0, 0, 7, 8'h33));
    vecs.push_back(mk(5, 3, 0,  1, 0, 0, 7, 8'h33));

    // reset state
    @(posedge clk); #1;
    chk("rst_tri_rdy", m_rdy, 0);
    chk("rst_px_vld", m_vld, 0);
    chk("rst_tri_done", m_done, 0);
    chk("rst_px_z", m_z, 0);
    chk("rst_px_x", m_x, 0);
    rst_n = 1'b1;
    chk("rdy_before_edge", m_rdy, 0);
    @(posedge clk); #1;
    chk("rdy_after_release", m_rdy, 1);

    run_tri(tris[1], 1, "single", acc);

    run_tri(tris[2], 2, "box4x2", acc);
    for (int k = 0; k < got_cyc.size(); k++)
      chk($sformatf("box4x2_cycle%0d", k), got_cyc[k], acc + 2 + k);

    stall_mode = 1'b1;
    run_tri(tris[2], 2, "stall", acc);
    stall_mode = 1'b0;

    run_tri(tris[4], 4, "cull1", acc);
    sel = 1'b1;
    run_tri(tris[4], 5, "cull0", acc);
    sel = 1'b0;

    // degenerate box
    d0 = done_cnt; v0 = vld_cnt;
    got_q.delete();
    send_tri(tris[6], acc);
    chk("deg_rdy_T", m_rdy, 0);
    @(posedge clk); #1;
    chk("deg_done_T1", m_done, 1);
    chk("deg_rdy_T1", m_rdy, 1);
    @(posedge clk); #1;
    chk("deg_done_once", m_done, 0);
    chk("deg_done_count", done_cnt - d0, 1);
    chk("deg_no_px", vld_cnt - v0, 0);

    // reset while pixel 3 sits in the output register
    got_q.delete(); got_cyc.delete();
    send_tri(tris[2], acc);
    n = 0;
    while (got_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    chk("mid_px3_valid", m_vld, 1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_px_vld", m_vld, 0);
    chk("mid_rst_tri_rdy", m_rdy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_rdy_held_low", m_rdy, 0);
    @(posedge clk); #1;
    chk("mid_rdy_after_release", m_rdy, 1);
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_more_px", got_q.size(), 2);
    run_tri(tris[1], 1, "after_rst", acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running req=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
